// File: rtl/usr_pkg.sv
// Shared mode encodings, FSM states and helpers
// for the universal shift register sequencer.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Shift-class modes run for a step count.
  function automatic logic is_shift(
    input logic [2:0] m
  );
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_seq_if.sv
// Request/status bundle of the shift register.
// master: start/mode/amount/din/sin_*; slave returns dout/sout_*/busy/done.
interface univ_shift_reg_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);

  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] dout;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, din,
    output sin_l, sin_r,
    input  dout, sout_msb, sout_lsb,
    input  busy, done
  );

  modport slave (
    input  start, mode, amount, din,
    input  sin_l, sin_r,
    output dout, sout_msb, sout_lsb,
    output busy, done
  );

endinterface

// File: rtl/usr_step_unit.sv
// Single-step next-value function of the shifter.
// cur/mode/sin_l/sin_r in, nxt out; non-shift modes pass cur.
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (mode)
      MODE_SHL: nxt = {cur[WIDTH-2:0], sin_r};
      MODE_SHR: nxt = {sin_l, cur[WIDTH-1:1]};
      MODE_ROL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR: nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_ASR: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register with multi-step sequencer.
// Ports: clk, rst (sync, active high), bus (slave side of the bundle).
module univ_shift_reg_seq
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  univ_shift_reg_seq_if.slave  bus
);

  localparam logic [AMT_W-1:0] L_WMAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] L_ONE  = AMT_W'(1);

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_dout, w_dout, w_step;
  logic [AMT_W-1:0] r_cnt, w_cnt, w_amt;
  logic [2:0]       r_mode, w_mode, w_step_mode;
  logic             r_busy, w_busy;
  logic             r_done, w_done;

  assign w_amt = (bus.amount > L_WMAX) ? L_WMAX : bus.amount;

  // Step 1 uses the live mode at the accept edge;
  // later steps use the latched copy.
  assign w_step_mode = (r_state == IDLE) ? bus.mode : r_mode;

  usr_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur   (r_dout),
    .mode  (w_step_mode),
    .sin_l (bus.sin_l),
    .sin_r (bus.sin_r),
    .nxt   (w_step)
  );

  always_comb begin
    w_state = r_state;
    w_dout  = r_dout;
    w_cnt   = r_cnt;
    w_mode  = r_mode;
    w_busy  = r_busy;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_mode = bus.mode;
          w_done = 1'b1;
          unique case (1'b1)
            (bus.mode == MODE_LOAD): w_dout = bus.din;
            (bus.mode == MODE_CLR):  w_dout = '0;
            is_shift(bus.mode): begin
              if (w_amt != '0) w_dout = w_step;
              if (w_amt > L_ONE) begin
                w_done  = 1'b0;
                w_busy  = 1'b1;
                w_cnt   = w_amt - L_ONE;
                w_state = SHIFT;
              end
            end
            default: ;
          endcase
        end
      end
      SHIFT: begin
        w_dout = w_step;
        w_cnt  = r_cnt - L_ONE;
        if (r_cnt == L_ONE) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_dout  <= w_dout;
      r_cnt   <= w_cnt;
      r_mode  <= w_mode;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign bus.dout     = r_dout;
  assign bus.sout_msb = r_dout[WIDTH-1];
  assign bus.sout_lsb = r_dout[0];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Self-checking bench for univ_shift_reg_seq
// (WIDTH=8) with an arithmetic reference model.
module tb_univ_shift_reg_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] m_dout = 8'h00;
  logic [7:0] fin;

  always #5 clk = ~clk;

  univ_shift_reg_seq_if #(.WIDTH(8), .AMT_W(4)) bus ();

  univ_shift_reg_seq #(
    .WIDTH (8),
    .AMT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One step by the rules: *2 is left, /2 is right,
  // fill bit weighted 1 or 128.
  function automatic logic [7:0] ref_step(
    input logic [2:0] md,
    input logic [7:0] v,
    input bit         sl,
    input bit         sr
  );
    int x;
    x = int'(v);
    case (md)
      3'd2: x = (x * 2 + int'(sr)) % 256;
      3'd3: x = x / 2 + int'(sl) * 128;
      3'd4: x = (x * 2) % 256 + x / 128;
      3'd5: x = x / 2 + (x % 2) * 128;
      3'd6: x = x / 2 + (x / 128) * 128;
      default: ;
    endcase
    return x[7:0];
  endfunction

  task automatic chk_state(
    input string tag,
    input bit    eb,
    input bit    ed
  );
    check({tag, ".dout"}, 32'(bus.dout), 32'(m_dout));
    check({tag, ".msb"}, 32'(bus.sout_msb), 32'(m_dout[7]));
    check({tag, ".lsb"}, 32'(bus.sout_lsb), 32'(m_dout[0]));
    check({tag, ".busy"}, 32'(bus.busy), 32'(eb));
    check({tag, ".done"}, 32'(bus.done), 32'(ed));
  endtask

  task automatic idle(input string tag);
    bus.start = 1'b0;
    @(negedge clk);
    chk_state(tag, 1'b0, 1'b0);
  endtask

  task automatic do_op(
    input  string      tag,
    input  logic [2:0] md,
    input  int         amt,
    input  logic [7:0] d,
    input  bit         rnd,
    input  bit         sl,
    input  bit         sr,
    output logic [7:0] res
  );
    int n;
    bit sh;
    bit cl;
    bit cr;
    n  = (amt > 8) ? 8 : amt;
    sh = (md >= 3'd2) && (md <= 3'd6);
    cl = rnd ? bit'($urandom_range(0, 1)) : sl;
    cr = rnd ? bit'($urandom_range(0, 1)) : sr;
    bus.start  = 1'b1;
    bus.mode   = md;
    bus.amount = 4'(amt);
    bus.din    = d;
    bus.sin_l  = cl;
    bus.sin_r  = cr;
    @(negedge clk);
    bus.start = 1'b0;
    case (md)
      3'd1: m_dout = d;
      3'd7: m_dout = 8'h00;
      3'd0: ;
      default: if (n > 0) m_dout = ref_step(md, m_dout, cl, cr);
    endcase
    chk_state({tag, ".e0"}, sh && n > 1, !(sh && n > 1));
    if (sh) begin
      for (int k = 2; k <= n; k++) begin
        cl = rnd ? bit'($urandom_range(0, 1)) : sl;
        cr = rnd ? bit'($urandom_range(0, 1)) : sr;
        bus.sin_l  = cl;
        bus.sin_r  = cr;
        bus.start  = bit'($urandom_range(0, 1));
        bus.mode   = 3'($urandom);
        bus.amount = 4'($urandom);
        bus.din    = 8'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        m_dout = ref_step(md, m_dout, cl, cr);
        chk_state({tag, ".step"}, k < n, k == n);
      end
    end
    res = m_dout;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.mode   = 3'd0;
    bus.amount = 4'd0;
    bus.din    = 8'h00;
    bus.sin_l  = 1'b0;
    bus.sin_r  = 1'b0;

    // 1. reset then load
    repeat (2) begin
      @(negedge clk);
      chk_state("rst", 1'b0, 1'b0);
    end
    rst = 1'b0;
    do_op("ld_a5", 3'd1, 0, 8'hA5, 0, 0, 0, fin);
    check("ld_a5.val", 32'(fin), 32'h00A5);
    idle("ld_a5.idle");

    // 2. SHL by 3 with ones fill
    do_op("shl3", 3'd2, 3, 8'h00, 0, 0, 1, fin);
    check("shl3.val", 32'(fin), 32'h002F);
    idle("shl3.idle");

    // 3. ASR by 2
    do_op("ld_96", 3'd1, 0, 8'h96, 0, 0, 0, fin);
    do_op("asr2", 3'd6, 2, 8'h00, 0, 0, 0, fin);
    check("asr2.val", 32'(fin), 32'h00E5);
    idle("asr2.idle");

    // 4. saturating rotate, then single ROR
    do_op("ld_3c", 3'd1, 0, 8'h3C, 0, 0, 0, fin);
    do_op("rol12", 3'd4, 12, 8'h00, 0, 0, 0, fin);
    check("rol12.val", 32'(fin), 32'h003C);
    idle("rol12.idle");
    do_op("ld_01", 3'd1, 0, 8'h01, 0, 0, 0, fin);
    do_op("ror1", 3'd5, 1, 8'h00, 0, 0, 0, fin);
    check("ror1.val", 32'(fin), 32'h0080);
    idle("ror1.idle");

    // 5. zero-step shift
    do_op("ld_5a", 3'd1, 0, 8'h5A, 0, 0, 0, fin);
    do_op("shr0", 3'd3, 0, 8'h00, 0, 1, 1, fin);
    check("shr0.val", 32'(fin), 32'h005A);
    idle("shr0.idle");

    // 6. ignored start while busy, reset mid-op
    do_op("ld_81", 3'd1, 0, 8'h81, 0, 0, 0, fin);
    bus.start  = 1'b1;
    bus.mode   = 3'd2;
    bus.amount = 4'd6;
    bus.sin_r  = 1'b1;
    bus.sin_l  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    m_dout = ref_step(3'd2, m_dout, 0, 1);
    chk_state("abort.s1", 1'b1, 1'b0);
    bus.start = 1'b1;
    bus.mode  = 3'd7;
    @(negedge clk);
    bus.start = 1'b0;
    m_dout = ref_step(3'd2, m_dout, 0, 1);
    chk_state("abort.s2", 1'b1, 1'b0);
    @(negedge clk);
    m_dout = ref_step(3'd2, m_dout, 0, 1);
    chk_state("abort.s3", 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    m_dout = 8'h00;
    chk_state("abort.rst", 1'b0, 1'b0);
    rst = 1'b0;
    repeat (6) idle("abort.after");

    // random ops, sometimes back to back in the done cycle
    for (int i = 0; i < 40; i++) begin
      do_op("rnd", 3'($urandom_range(0, 7)), $urandom_range(0, 15),
            8'($urandom), 1, 0, 0, fin);
      if ($urandom_range(0, 1) == 1) idle("rnd.idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
